// File: rtl/lc3_cc_bank.sv
// LC-3 condition-code unit: N/Z/P flags, registered BEN, and a LIFO of saved flags for interrupt nesting.
// Optional sticky overflow/underflow flags with err_clr are enabled by defining LC3_CC_STACK_ERR_EN.
module lc3_cc_bank #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int COND_LSB = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             main_bus,
    input  logic [WIDTH-1:0]             IR,
    input  logic                         LDCC,
    input  logic                         LDBEN,
    input  logic                         LDPSR,
    input  logic [2:0]                   psr_nzp,
    input  logic                         cc_push,
    input  logic                         cc_pop,
    output logic [2:0]                   nzp,
    output logic                         BEN,
    output logic [$clog2(DEPTH+1)-1:0]   cc_depth,
    output logic                         cc_full,
`ifdef LC3_CC_STACK_ERR_EN
    input  logic                         err_clr,
    output logic                         cc_ovf,
    output logic                         cc_udf,
`endif
    output logic                         cc_empty
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] FULL_C  = DW'(DEPTH);
    localparam logic [DW-1:0] EMPTY_C = DW'(0);
    localparam logic [DW-1:0] ONE_C   = DW'(1);

    // Classify a bus value into one-hot {N,Z,P}.
    function automatic logic [2:0] classify(input logic [WIDTH-1:0] value);
        logic n_v;
        logic z_v;
        n_v = value[WIDTH-1];
        z_v = (value == {WIDTH{1'b0}});
        return {n_v, z_v, ~n_v & ~z_v};
    endfunction

    logic [2:0]    nzp_r;
    logic          ben_r;
    logic [DW-1:0] depth_r;
    logic          full_r;
    logic          empty_r;
    logic [2:0]    stack_r [DEPTH];

    logic          push_req_s;
    logic          pop_req_s;
    logic          push_ok_s;
    logic          pop_ok_s;
    logic [DW-1:0] depth_m1_s;
    logic [AW-1:0] wr_idx_s;
    logic [AW-1:0] rd_idx_s;
    logic [2:0]    nzp_nx_s;
    logic [DW-1:0] depth_nx_s;
    logic          ben_nx_s;
    logic [2:0]    ir_cond_s;

    // A simultaneous push and pop cancels both; legality gates against full/empty.
    always_comb begin
        push_req_s = cc_push & ~cc_pop;
        pop_req_s  = cc_pop & ~cc_push;
        push_ok_s  = push_req_s & (depth_r != FULL_C);
        pop_ok_s   = pop_req_s & (depth_r != EMPTY_C);
        depth_m1_s = depth_r - ONE_C;
        wr_idx_s   = depth_r[AW-1:0];
        rd_idx_s   = depth_m1_s[AW-1:0];
        ir_cond_s  = IR[COND_LSB+2:COND_LSB];
        ben_nx_s   = |(ir_cond_s & nzp_r);
    end

    // Next flags: legal pop beats PSR write, which beats bus classification.
    always_comb begin
        nzp_nx_s = nzp_r;
        if (pop_ok_s) begin
            nzp_nx_s = stack_r[rd_idx_s];
        end else if (LDPSR) begin
            nzp_nx_s = psr_nzp;
        end else if (LDCC) begin
            nzp_nx_s = classify(main_bus);
        end else begin
            nzp_nx_s = nzp_r;
        end
    end

    // Next stack depth.
    always_comb begin
        depth_nx_s = depth_r;
        if (push_ok_s) begin
            depth_nx_s = depth_r + ONE_C;
        end else if (pop_ok_s) begin
            depth_nx_s = depth_m1_s;
        end else begin
            depth_nx_s = depth_r;
        end
    end

    // Flag, BEN and depth registers; full/empty are registered from the next depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            nzp_r   <= 3'b010;
            ben_r   <= 1'b0;
            depth_r <= EMPTY_C;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            nzp_r   <= nzp_nx_s;
            ben_r   <= LDBEN ? ben_nx_s : ben_r;
            depth_r <= depth_nx_s;
            full_r  <= (depth_nx_s == FULL_C);
            empty_r <= (depth_nx_s == EMPTY_C);
        end
    end

    // Stack storage is deliberately not reset; depth alone marks entries valid.
    always_ff @(posedge clk) begin
        if (!rst && push_ok_s) begin
            stack_r[wr_idx_s] <= nzp_r;
        end
    end

`ifdef LC3_CC_STACK_ERR_EN
    logic ovf_r;
    logic udf_r;

    // Sticky error flags; a new violation takes precedence over err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (push_req_s && (depth_r == FULL_C)) begin
                ovf_r <= 1'b1;
            end else if (err_clr) begin
                ovf_r <= 1'b0;
            end
            if (pop_req_s && (depth_r == EMPTY_C)) begin
                udf_r <= 1'b1;
            end else if (err_clr) begin
                udf_r <= 1'b0;
            end
        end
    end

    assign cc_ovf = ovf_r;
    assign cc_udf = udf_r;
`endif

    assign nzp      = nzp_r;
    assign BEN      = ben_r;
    assign cc_depth = depth_r;
    assign cc_full  = full_r;
    assign cc_empty = empty_r;

endmodule

// File: tb/tb_lc3_cc_bank.sv
// Scoreboard bench for lc3_cc_bank: expected {nzp,BEN,depth,full,empty} queued per driven cycle, checked one edge later.
module tb_lc3_cc_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] main_bus;
    logic [15:0] IR;
    logic        LDCC, LDBEN, LDPSR, cc_push, cc_pop;
    logic [2:0]  psr_nzp;
    logic [2:0]  nzp;
    logic        BEN;
    logic [2:0]  cc_depth;
    logic        cc_full, cc_empty;
`ifdef LC3_CC_STACK_ERR_EN
    logic        err_clr;
    logic        cc_ovf, cc_udf;
`endif

    int tests = 0;
    int failed = 0;

    lc3_cc_bank #(.WIDTH(16), .DEPTH(4), .COND_LSB(9)) dut (
        .clk(clk), .rst(rst), .main_bus(main_bus), .IR(IR),
        .LDCC(LDCC), .LDBEN(LDBEN), .LDPSR(LDPSR), .psr_nzp(psr_nzp),
        .cc_push(cc_push), .cc_pop(cc_pop), .nzp(nzp), .BEN(BEN),
        .cc_depth(cc_depth), .cc_full(cc_full),
`ifdef LC3_CC_STACK_ERR_EN
        .err_clr(err_clr), .cc_ovf(cc_ovf), .cc_udf(cc_udf),
`endif
        .cc_empty(cc_empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        r, cc, ben, psr, push, pop;
        logic [2:0]  pv;
        logic [15:0] bus;
        logic [2:0]  irc;
    } stim_t;

    typedef struct {
        string      name;
        logic [8:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t x;

    logic [8:0] obs;
    assign obs = {nzp, BEN, cc_depth, cc_full, cc_empty};

    function automatic stim_t st(input logic r, cc, ben, psr, push, pop,
                                 input logic [2:0] pv, input logic [15:0] bus,
                                 input logic [2:0] irc);
        return '{r, cc, ben, psr, push, pop, pv, bus, irc};
    endfunction

    function automatic logic [8:0] ex(input logic [2:0] n, input logic b, input logic [2:0] d);
        return {n, b, d, (d == 3'd4), (d == 3'd0)};
    endfunction

    function automatic logic [2:0] ref_class(input logic [15:0] v);
        if (v[15]) return 3'b100;
        else if (v == 16'h0000) return 3'b010;
        else return 3'b001;
    endfunction

    task automatic apply(input stim_t s);
        rst = s.r; LDCC = s.cc; LDBEN = s.ben; LDPSR = s.psr;
        cc_push = s.push; cc_pop = s.pop; psr_nzp = s.pv;
        main_bus = s.bus; IR = {4'b0000, s.irc, 9'b0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s[2];
        logic [8:0] e[2];
        s = '{st(1, 1, 1, 1, 1, 0, 3'b111, 16'h8000, 3'b111),
              st(0, 0, 0, 0, 0, 0, 3'b000, 16'h0000, 3'b000)};
        e = '{ex(3'b010, 0, 3'd0), ex(3'b010, 0, 3'd0)};
        for (int i = 0; i < 2; i++) begin
            apply(s[i]);
            sb.push_back('{"reset", e[i]});
            tick();
            x = sb.pop_front();
            tests++;
            if (obs !== x.v) begin
                failed++;
                $display("FAIL %s step %0d: got %b expected %b", x.name, i, obs, x.v);
            end
        end
    endtask

    task automatic test_ldcc();
        stim_t s[5];
        logic [8:0] e[5];
        s = '{st(0, 1, 0, 0, 0, 0, 3'b000, 16'h8000, 3'b000),
              st(0, 1, 0, 0, 0, 0, 3'b000, 16'h0000, 3'b000),
              st(0, 1, 0, 0, 0, 0, 3'b000, 16'h0001, 3'b000),
              st(0, 1, 0, 0, 0, 0, 3'b000, 16'hFFFF, 3'b000),
              st(0, 1, 0, 0, 0, 0, 3'b000, 16'h7FFF, 3'b000)};
        e = '{ex(3'b100, 0, 3'd0), ex(3'b010, 0, 3'd0), ex(3'b001, 0, 3'd0),
              ex(3'b100, 0, 3'd0), ex(3'b001, 0, 3'd0)};
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            sb.push_back('{"ldcc", e[i]});
            tick();
            x = sb.pop_front();
            tests++;
            if (obs !== x.v) begin
                failed++;
                $display("FAIL %s step %0d: got %b expected %b", x.name, i, obs, x.v);
            end
        end
    endtask

    task automatic test_ben();
        stim_t s[5];
        logic [8:0] e[5];
        s = '{st(0, 0, 1, 0, 0, 0, 3'b000, 16'h0000, 3'b001),
              st(0, 0, 1, 0, 0, 0, 3'b000, 16'h0000, 3'b110),
              st(0, 1, 1, 0, 0, 0, 3'b000, 16'h0000, 3'b010),
              st(0, 0, 1, 0, 0, 0, 3'b000, 16'h0000, 3'b010),
              st(0, 0, 0, 0, 0, 0, 3'b000, 16'h0000, 3'b000)};
        e = '{ex(3'b001, 1, 3'd0), ex(3'b001, 0, 3'd0), ex(3'b010, 0, 3'd0),
              ex(3'b010, 1, 3'd0), ex(3'b010, 1, 3'd0)};
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            sb.push_back('{"ben", e[i]});
            tick();
            x = sb.pop_front();
            tests++;
            if (obs !== x.v) begin
                failed++;
                $display("FAIL %s step %0d: got %b expected %b", x.name, i, obs, x.v);
            end
        end
    endtask

    task automatic test_nesting();
        stim_t s[5];
        logic [8:0] e[5];
        s = '{st(0, 1, 0, 0, 0, 0, 3'b000, 16'h8000, 3'b000),
              st(0, 0, 0, 1, 1, 0, 3'b010, 16'h0000, 3'b000),
              st(0, 1, 0, 0, 1, 0, 3'b000, 16'h0005, 3'b000),
              st(0, 1, 0, 1, 0, 1, 3'b111, 16'h0000, 3'b000),
              st(0, 0, 0, 0, 0, 1, 3'b000, 16'h0000, 3'b000)};
        e = '{ex(3'b100, 1, 3'd0), ex(3'b010, 1, 3'd1), ex(3'b001, 1, 3'd2),
              ex(3'b010, 1, 3'd1), ex(3'b100, 1, 3'd0)};
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            sb.push_back('{"nesting", e[i]});
            tick();
            x = sb.pop_front();
            tests++;
            if (obs !== x.v) begin
                failed++;
                $display("FAIL %s step %0d: got %b expected %b", x.name, i, obs, x.v);
            end
        end
    endtask

    task automatic test_overflow();
        stim_t s[9];
        logic [8:0] e[9];
        s = '{st(0, 0, 0, 1, 1, 0, 3'b001, 16'h0000, 3'b000),
              st(0, 0, 0, 1, 1, 0, 3'b010, 16'h0000, 3'b000),
              st(0, 0, 0, 1, 1, 0, 3'b000, 16'h0000, 3'b000),
              st(0, 0, 0, 1, 1, 0, 3'b111, 16'h0000, 3'b000),
              st(0, 0, 0, 1, 1, 0, 3'b011, 16'h0000, 3'b000),
              st(0, 0, 0, 0, 0, 1, 3'b000, 16'h0000, 3'b000),
              st(0, 0, 0, 0, 0, 1, 3'b000, 16'h0000, 3'b000),
              st(0, 0, 0, 0, 0, 1, 3'b000, 16'h0000, 3'b000),
              st(0, 0, 0, 0, 0, 1, 3'b000, 16'h0000, 3'b000)};
        e = '{ex(3'b001, 1, 3'd1), ex(3'b010, 1, 3'd2), ex(3'b000, 1, 3'd3),
              ex(3'b111, 1, 3'd4), ex(3'b011, 1, 3'd4), ex(3'b000, 1, 3'd3),
              ex(3'b010, 1, 3'd2), ex(3'b001, 1, 3'd1), ex(3'b100, 1, 3'd0)};
        for (int i = 0; i < 9; i++) begin
            apply(s[i]);
            sb.push_back('{"overflow", e[i]});
            tick();
            x = sb.pop_front();
            tests++;
            if (obs !== x.v) begin
                failed++;
                $display("FAIL %s step %0d: got %b expected %b", x.name, i, obs, x.v);
            end
        end
`ifdef LC3_CC_STACK_ERR_EN
        tests++;
        if (cc_ovf !== 1'b1) begin
            failed++;
            $display("FAIL ovf_sticky: got %b expected 1", cc_ovf);
        end
        apply(st(0, 0, 0, 0, 0, 0, 3'b000, 16'h0000, 3'b000));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests++;
        if (cc_ovf !== 1'b0) begin
            failed++;
            $display("FAIL ovf_clear: got %b expected 0", cc_ovf);
        end
`endif
    endtask

    task automatic test_underflow();
        stim_t s[8];
        logic [8:0] e[8];
        s = '{st(0, 1, 0, 0, 0, 1, 3'b000, 16'hFFFF, 3'b000),
              st(0, 0, 0, 1, 0, 1, 3'b001, 16'h0000, 3'b000),
              st(0, 0, 0, 1, 1, 0, 3'b010, 16'h0000, 3'b000),
              st(0, 0, 0, 1, 1, 0, 3'b100, 16'h0000, 3'b000),
              st(0, 0, 0, 0, 1, 1, 3'b000, 16'h0000, 3'b000),
              st(0, 0, 0, 1, 1, 1, 3'b110, 16'h0000, 3'b000),
              st(0, 0, 0, 0, 0, 1, 3'b000, 16'h0000, 3'b000),
              st(0, 0, 0, 0, 0, 1, 3'b000, 16'h0000, 3'b000)};
        e = '{ex(3'b100, 1, 3'd0), ex(3'b001, 1, 3'd0), ex(3'b010, 1, 3'd1),
              ex(3'b100, 1, 3'd2), ex(3'b100, 1, 3'd2), ex(3'b110, 1, 3'd2),
              ex(3'b010, 1, 3'd1), ex(3'b001, 1, 3'd0)};
        for (int i = 0; i < 8; i++) begin
            apply(s[i]);
            sb.push_back('{"underflow", e[i]});
            tick();
            x = sb.pop_front();
            tests++;
            if (obs !== x.v) begin
                failed++;
                $display("FAIL %s step %0d: got %b expected %b", x.name, i, obs, x.v);
            end
`ifdef LC3_CC_STACK_ERR_EN
            if (i == 0) begin
                tests++;
                if (cc_udf !== 1'b1) begin
                    failed++;
                    $display("FAIL udf_set: got %b expected 1", cc_udf);
                end
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        stim_t s[6];
        logic [8:0] e[6];
        s = '{st(0, 0, 0, 0, 1, 0, 3'b000, 16'h0000, 3'b000),
              st(0, 0, 0, 1, 1, 0, 3'b100, 16'h0000, 3'b000),
              st(0, 0, 0, 0, 1, 0, 3'b000, 16'h0000, 3'b000),
              st(1, 0, 0, 0, 0, 1, 3'b000, 16'h0000, 3'b000),
              st(0, 0, 0, 0, 0, 1, 3'b000, 16'h0000, 3'b000),
              st(0, 1, 0, 0, 0, 1, 3'b000, 16'h8000, 3'b000)};
        e = '{ex(3'b001, 1, 3'd1), ex(3'b100, 1, 3'd2), ex(3'b100, 1, 3'd3),
              ex(3'b010, 0, 3'd0), ex(3'b010, 0, 3'd0), ex(3'b100, 0, 3'd0)};
        for (int i = 0; i < 6; i++) begin
            apply(s[i]);
            sb.push_back('{"reset_mid", e[i]});
            tick();
            x = sb.pop_front();
            tests++;
            if (obs !== x.v) begin
                failed++;
                $display("FAIL %s step %0d: got %b expected %b", x.name, i, obs, x.v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bus;
        for (int i = 0; i < 8; i++) begin
            bus = 16'($urandom);
            if (i == 0) bus = 16'h0000;
            apply(st(0, 1, 0, 0, 0, 0, 3'b000, bus, 3'b000));
            sb.push_back('{"back_to_back", ex(ref_class(bus), 0, 3'd0)});
            tick();
            x = sb.pop_front();
            tests++;
            if (obs !== x.v) begin
                failed++;
                $display("FAIL %s bus %h: got %b expected %b", x.name, bus, obs, x.v);
            end
        end
    endtask

    initial begin
`ifdef LC3_CC_STACK_ERR_EN
        err_clr = 1'b0;
`endif
        apply(st(1, 0, 0, 0, 0, 0, 3'b000, 16'h0000, 3'b000));
        tick();
        test_reset();
        test_ldcc();
        test_ben();
        test_nesting();
        test_overflow();
        test_underflow();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/lc3_cc_bank.md
# lc3_cc_bank

Parametrised condition-code unit for the LC-3 datapath that also saves and restores condition codes across interrupts. It holds the N/Z/P flags, derives them from a WIDTH-bit bus value on LDCC, and computes the registered branch-enable (BEN) from the IR nzp field. It adds a DEPTH-entry LIFO of saved condition codes, pushed on interrupt entry and popped on RTI, plus a direct PSR-write path. It sits beside the IR and main bus, controlled by the microsequencer.

## Interface
- WIDTH, 16: bus and IR width; must be at least 12.
- DEPTH, 4: number of saved-CC stack entries; must be at least 1.
- COND_LSB, 9: IR bit index of the p field; z is COND_LSB+1 and n is COND_LSB+2; COND_LSB+2 must be ≤ WIDTH-1.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- main_bus  in  WIDTH  value to classify
- IR  in  WIDTH  instruction register
- LDCC  in  1  load flags from main_bus
- LDBEN  in  1  load BEN
- LDPSR  in  1  load flags from psr_nzp
- psr_nzp  in  3  {N,Z,P} for the PSR write
- cc_push  in  1  save current flags onto stack
- cc_pop  in  1  restore flags from stack top
- nzp  out  3  current {N,Z,P}, registered
- BEN  out  1  branch enable, registered
- cc_depth  out  clog2(DEPTH+1)  occupied entries
- cc_full / cc_empty  out  1  cc_depth==DEPTH / cc_depth==0

## Operation
- Reset (rst=1 at an edge): nzp=3'b010, BEN=0, cc_depth=0, cc_empty=1, cc_full=0. Reset overrides every other input in that cycle.
- Classify: N=main_bus[WIDTH-1]; Z=(main_bus==0); P=!N&&!Z. Exactly one flag is set after LDCC.
- nzp update priority: cc_pop (when legal) > LDPSR > LDCC. The highest active source wins; lower-priority sources are discarded that cycle.
- LDPSR loads psr_nzp verbatim; illegal encodings (000, multi-hot) are accepted unchanged.
- cc_push saves the pre-edge nzp at index cc_depth, then cc_depth+1. The push is independent of a same-cycle LDCC/LDPSR, so interrupt entry can save the old flags and load new ones in one cycle.
- cc_pop loads nzp from the top entry, then cc_depth-1.
- cc_push and cc_pop together: both are ignored. Stack and depth are unchanged; LDPSR/LDCC still apply.
- Push when full: ignored, stack unchanged. Pop when empty: ignored, and nzp follows LDPSR/LDCC as if cc_pop were low.
- BEN on LDBEN: BEN <= (IR[n]&N)|(IR[z]&Z)|(IR[p]&P), using pre-edge nzp. It holds otherwise.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Flag latency: 1 cycle after LDCC/LDPSR/cc_pop.
- LDCC and LDBEN in the same cycle: BEN uses the old flags; the new flags are visible to BEN at the next LDBEN.
- cc_depth, cc_full and cc_empty update at the edge of a legal push or pop.
- Stack contents are not cleared by rst, only invalidated by cc_depth=0.

## Configuration
- LC3_CC_STACK_ERR_EN defined: adds outputs cc_ovf and cc_udf (1 bit, sticky) and input err_clr (1 bit).
  - cc_ovf sets on a push when full.
  - cc_udf sets on a pop when empty.
  - Both clear on rst or err_clr. If a set event and err_clr coincide, the set wins.
  - A simultaneous push and pop sets neither flag.
- Not defined: these ports do not exist; violations are silently ignored as described in Operation.

## Test plan
- Reset then idle: nzp=010, BEN=0, cc_depth=0, cc_empty=1. Then LDCC with bus=16'h8000 -> nzp=100 one cycle later; bus=16'h0000 -> 010; bus=16'h0001 -> 001.
- BEN: nzp=001, IR[11:9]=001, LDBEN -> BEN=1. IR[11:9]=110 -> BEN=0. LDCC (bus=0) and LDBEN with IR[11:9]=010 in the same cycle -> BEN=0 (old flags); a second LDBEN -> BEN=1.
- Interrupt nesting: nzp=100; push+LDPSR(010); push+LDCC(bus=5) -> depth=2, nzp=001. Pop -> 010; pop -> 100, depth=0.
- Overflow (DEPTH=4): 5 pushes -> depth stays 4 and the stack is unchanged. With LC3_CC_STACK_ERR_EN, cc_ovf=1 until err_clr.
- Underflow and conflicts: pop on empty with LDCC (bus=16'hFFFF) -> nzp=100, depth=0 (cc_udf=1 if enabled). Push+pop together with depth=2 -> depth stays 2, nzp unchanged.
- Reset mid-stack: depth=3, rst pulse -> depth=0, nzp=010. A following pop has no effect on nzp.
